uart_cfg_fifo: RTL and testbench
================================

Name: uart_cfg_fifo

Overview:
Full-duplex UART with runtime-selectable character format (5..DATA_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits). Adds a parametrised receive FIFO and per-byte parity error tagging. AXI4-Stream transmit and receive sides. Sits between on-chip stream logic (debug display, command parser) and the BL616 UART pins.

Parameters:
DATA_WIDTH, 8, maximum data bits per character; also the AXIS data width.
FIFO_AW, 4, RX FIFO address width; depth = 2**FIFO_AW entries.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
s_axis_tdata  in  DATA_WIDTH  TX character; bits above cfg_data_bits are ignored
s_axis_tvalid  in  1  TX valid
s_axis_tready  out  1  TX ready
m_axis_tdata  out  DATA_WIDTH  RX character from FIFO head; unused upper bits are 0
m_axis_tuser  out  1  parity error flag for the head character
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  RX pop
rxd  in  1  serial in (asynchronous)
txd  out  1  serial out
tx_busy  out  1  TX frame in progress
rx_busy  out  1  RX frame in progress
rx_overrun_error  out  1  one-cycle pulse: completed character dropped, FIFO full
rx_frame_error  out  1  one-cycle pulse: stop bit sampled 0
rx_parity_error  out  1  one-cycle pulse: parity mismatch
rx_fifo_count  out  FIFO_AW+1  RX FIFO occupancy
prescale  in  16  bit time = 8*prescale clk cycles; 0 is treated as 1
cfg_data_bits  in  4  data bits; <5 -> 5, >DATA_WIDTH -> DATA_WIDTH
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  1 = two stop bits (TX); RX checks the first stop bit only

Behaviour:
- Reset (async assert, sync release): txd=1, s_axis_tready=0 while asserted, then 1; tx_busy=0, rx_busy=0, all error pulses 0, FIFO empty, m_axis_tvalid=0, m_axis_tuser=0, rx_fifo_count=0. Reset mid-frame aborts both engines immediately; txd goes to 1.
- prescale and cfg_* are latched at frame start (TX on handshake, RX on start detect). Mid-frame changes do not affect the current frame.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP (1 or 2 bit times) -> IDLE.
- TX handshake: s_axis_tready=1 only in IDLE. On tvalid&tready, txd=0 from the next cycle and tx_busy=1. Data is sent LSB first. Even parity bit = XOR of the data bits; odd = its inverse.
- tx_busy drops, and tready rises, on the cycle after the last stop bit period ends. No back-to-back gap beyond that one cycle.
- RX input: 2-flop synchroniser; all detection uses the synchronised signal.
- RX FSM: IDLE -> START_CHK -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - Falling edge in IDLE: rx_busy=1, wait 4*prescale cycles, resample.
  - If the resample is high: false start, return to IDLE, no flags.
  - Otherwise sample each following bit at 8*prescale intervals (bit centre).
- RX completion, at the stop sample:
  - Stop=0: rx_frame_error pulse, character discarded. A break counts as a frame error.
  - Stop=1: character pushed with tuser = parity mismatch; rx_parity_error pulses on mismatch.
  - rx_busy falls the same cycle; a new start edge is accepted from the next cycle.
- RX FIFO: first-word-fall-through; count increments on push, decrements on pop.
  - Push when full with no pop: character dropped, rx_overrun_error pulse.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo 2**FIFO_AW.
- All error outputs are single-cycle pulses, never sticky.

Test Plan:
- prescale=1, 8N1, send 0xA5 -> txd 0 | 1,0,1,0,0,1,0,1 | 1, each level 8 cycles; tx_busy high 80 cycles; next tready 1 cycle after.
- 7E2, send 0x83 -> 7 data bits 1,1,0,0,0,0,0, parity 0, stop 1,1; frame 88 cycles; bit 7 ignored.
- Loopback txd->rxd, 8O1, byte 0x3C -> m_axis_tdata=0x3C, tuser=0, count=1. Forced parity bit 0 -> tuser=1, one rx_parity_error pulse.
- RX frame with stop bit 0 (0x00 break) -> one rx_frame_error pulse, count stays 0, rx_busy falls.
- FIFO_AW=2, tready=0, 5 bytes 0x11..0x55 -> count=4, one overrun pulse on the 5th. Drain gives 0x11,0x22,0x33,0x44. Push plus pop on a full FIFO keeps count=4.
- rxd low 2 cycles (prescale=1) -> no data, no flags, rx_busy=0 by cycle 6. rst_n low mid-TX -> txd=1 immediately, tready=1 after release.

Source files
------------

// File: rtl/uart_cfg_fifo.sv
// Full-duplex UART with runtime character format (5..DATA_WIDTH bits, parity, 1/2 stop bits),
// AXI4-Stream TX/RX sides and a first-word-fall-through RX FIFO tagging parity errors.
module uart_cfg_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_AW    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  txd,
   output logic                  tx_busy,
   output logic                  rx_busy,
   output logic                  rx_overrun_error,
   output logic                  rx_frame_error,
   output logic                  rx_parity_error,
   output logic [FIFO_AW:0]      rx_fifo_count,
   input  logic [15:0]           prescale,
   input  logic [3:0]            cfg_data_bits,
   input  logic [1:0]            cfg_parity,
   input  logic                  cfg_stop2
);

   localparam int unsigned Depth = 2 ** FIFO_AW;

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

   logic [15:0]           presc_eff;
   logic [18:0]           bit_len, half_len;
   logic [3:0]            bits_c;
   logic [DATA_WIDTH-1:0] bits_mask;
   logic                  par_en_c, par_odd_c;

   always_comb begin
      presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
      bit_len   = {presc_eff, 3'b000};
      half_len  = {1'b0, presc_eff, 2'b00};
      if (cfg_data_bits < 4'd5) bits_c = 4'd5;
      else if (32'(cfg_data_bits) > DATA_WIDTH) bits_c = 4'(DATA_WIDTH);
      else bits_c = cfg_data_bits;
      for (int i = 0; i < DATA_WIDTH; i++) bits_mask[i] = (i < int'(bits_c));
      par_en_c  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_odd_c = (cfg_parity == 2'b10);
   end

   // ---------------- transmitter ----------------
   tx_state_e             tx_state_q, tx_state_d;
   logic [18:0]           tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
   logic [3:0]            tx_idx_q, tx_idx_d, tx_bits_q, tx_bits_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
   logic                  tx_stop2_q, tx_stop2_d, rst_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q   <= TxIdle;
         tx_cnt_q     <= '0;
         tx_len_q     <= '0;
         tx_idx_q     <= '0;
         tx_bits_q    <= '0;
         tx_shift_q   <= '0;
         tx_par_en_q  <= 1'b0;
         tx_par_bit_q <= 1'b0;
         tx_stop2_q   <= 1'b0;
         rst_done_q   <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_len_q     <= tx_len_d;
         tx_idx_q     <= tx_idx_d;
         tx_bits_q    <= tx_bits_d;
         tx_shift_q   <= tx_shift_d;
         tx_par_en_q  <= tx_par_en_d;
         tx_par_bit_q <= tx_par_bit_d;
         tx_stop2_q   <= tx_stop2_d;
         rst_done_q   <= 1'b1;
      end
   end

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_len_d     = tx_len_q;
      tx_idx_d     = tx_idx_q;
      tx_bits_d    = tx_bits_q;
      tx_shift_d   = tx_shift_q;
      tx_par_en_d  = tx_par_en_q;
      tx_par_bit_d = tx_par_bit_q;
      tx_stop2_d   = tx_stop2_q;
      if (tx_state_q == TxIdle) begin
         if (s_axis_tvalid && s_axis_tready) begin
            tx_state_d   = TxStart;
            tx_cnt_d     = bit_len - 19'd1;
            tx_len_d     = bit_len;
            tx_idx_d     = '0;
            tx_bits_d    = bits_c;
            tx_shift_d   = s_axis_tdata & bits_mask;
            tx_par_en_d  = par_en_c;
            tx_par_bit_d = (^(s_axis_tdata & bits_mask)) ^ par_odd_c;
            tx_stop2_d   = cfg_stop2;
         end
      end else if (tx_cnt_q != '0) begin
         tx_cnt_d = tx_cnt_q - 19'd1;
      end else begin
         tx_cnt_d = tx_len_q - 19'd1;
         case (tx_state_q)
            TxStart: begin
               tx_state_d = TxData;
               tx_idx_d   = '0;
            end
            TxData: begin
               tx_shift_d = tx_shift_q >> 1;
               tx_idx_d   = tx_idx_q + 4'd1;
               if (tx_idx_q == tx_bits_q - 4'd1) begin
                  tx_idx_d   = '0;
                  tx_state_d = tx_par_en_q ? TxParity : TxStop;
               end
            end
            TxParity: tx_state_d = TxStop;
            TxStop: begin
               // tx_idx_q counts completed stop bits
               if (tx_stop2_q && (tx_idx_q == 4'd0)) tx_idx_d = 4'd1;
               else tx_state_d = TxIdle;
            end
            default: tx_state_d = TxIdle;
         endcase
      end
   end

   always_comb begin
      case (tx_state_q)
         TxStart:  txd = 1'b0;
         TxData:   txd = tx_shift_q[0];
         TxParity: txd = tx_par_bit_q;
         default:  txd = 1'b1;
      endcase
      tx_busy       = (tx_state_q != TxIdle);
      s_axis_tready = (tx_state_q == TxIdle) && rst_done_q;
   end

   // ---------------- receiver ----------------
   rx_state_e             rx_state_q, rx_state_d;
   logic                  rx_s1_q, rx_s2_q, rx_prev_q;
   logic [18:0]           rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
   logic [3:0]            rx_idx_q, rx_idx_d, rx_bits_q, rx_bits_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
   logic                  frame_err_q, frame_err_d, par_err_q, par_err_d, ovr_q, ovr_d;
   logic                  push_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RxIdle;
         rx_cnt_q    <= '0;
         rx_len_q    <= '0;
         rx_idx_q    <= '0;
         rx_bits_q   <= '0;
         rx_data_q   <= '0;
         rx_par_en_q <= 1'b0;
         rx_odd_q    <= 1'b0;
         rx_perr_q   <= 1'b0;
         frame_err_q <= 1'b0;
         par_err_q   <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         rx_s1_q     <= rxd;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_len_q    <= rx_len_d;
         rx_idx_q    <= rx_idx_d;
         rx_bits_q   <= rx_bits_d;
         rx_data_q   <= rx_data_d;
         rx_par_en_q <= rx_par_en_d;
         rx_odd_q    <= rx_odd_d;
         rx_perr_q   <= rx_perr_d;
         frame_err_q <= frame_err_d;
         par_err_q   <= par_err_d;
         ovr_q       <= ovr_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_len_d    = rx_len_q;
      rx_idx_d    = rx_idx_q;
      rx_bits_d   = rx_bits_q;
      rx_data_d   = rx_data_q;
      rx_par_en_d = rx_par_en_q;
      rx_odd_d    = rx_odd_q;
      rx_perr_d   = rx_perr_q;
      frame_err_d = 1'b0;
      push_req    = 1'b0;
      if (rx_state_q == RxIdle) begin
         if (rx_prev_q && !rx_s2_q) begin
            rx_state_d  = RxStart;
            rx_cnt_d    = half_len - 19'd1;
            rx_len_d    = bit_len;
            rx_bits_d   = bits_c;
            rx_par_en_d = par_en_c;
            rx_odd_d    = par_odd_c;
            rx_data_d   = '0;
            rx_perr_d   = 1'b0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 19'd1;
      end else begin
         rx_cnt_d = rx_len_q - 19'd1;
         case (rx_state_q)
            RxStart: begin
               rx_idx_d   = '0;
               rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
            RxData: begin
               for (int i = 0; i < DATA_WIDTH; i++) begin
                  if (i == int'(rx_idx_q)) rx_data_d[i] = rx_s2_q;
               end
               rx_idx_d = rx_idx_q + 4'd1;
               if (rx_idx_q == rx_bits_q - 4'd1) begin
                  rx_state_d = rx_par_en_q ? RxParity : RxStop;
               end
            end
            RxParity: begin
               rx_perr_d  = rx_s2_q ^ (^rx_data_q) ^ rx_odd_q;
               rx_state_d = RxStop;
            end
            RxStop: begin
               rx_state_d  = RxIdle;
               frame_err_d = !rx_s2_q;
               push_req    = rx_s2_q;
            end
            default: rx_state_d = RxIdle;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [DATA_WIDTH:0]  mem_q [Depth];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;
   logic                 fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [DATA_WIDTH:0]  head;

   always_comb begin
      fifo_empty  = (count_q == '0);
      fifo_full   = count_q[FIFO_AW];
      fifo_pop    = m_axis_tready && !fifo_empty;
      // a pop in the same cycle frees the slot for a push into a full FIFO
      fifo_push   = push_req && (!fifo_full || fifo_pop);
      ovr_d       = push_req && fifo_full && !fifo_pop;
      par_err_d   = push_req && rx_perr_q;
      wr_ptr_d    = wr_ptr_q + FIFO_AW'(fifo_push);
      rd_ptr_d    = rd_ptr_q + FIFO_AW'(fifo_pop);
      count_d     = count_q + (FIFO_AW + 1)'(fifo_push) - (FIFO_AW + 1)'(fifo_pop);
      head        = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (fifo_push) mem_q[wr_ptr_q] <= {rx_perr_q, rx_data_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      m_axis_tvalid    = !fifo_empty;
      m_axis_tdata     = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
      m_axis_tuser     = !fifo_empty && head[DATA_WIDTH];
      rx_fifo_count    = count_q;
      rx_busy          = (rx_state_q != RxIdle);
      rx_frame_error   = frame_err_q;
      rx_parity_error  = par_err_q;
      rx_overrun_error = ovr_q;
   end

endmodule

// File: tb/tb_uart_cfg_fifo.sv
// Directed bench for uart_cfg_fifo: table-driven TX frames plus hand-written RX, FIFO and
// reset sequences. Inputs change on the falling edge, outputs are sampled there too.
module tb_uart_cfg_fifo;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tuser, m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          rxd, txd, tx_busy, rx_busy;
   logic          rx_overrun_error, rx_frame_error, rx_parity_error;
   logic [AW:0]   rx_fifo_count;
   logic [15:0]   prescale = 16'd1;
   logic [3:0]    cfg_data_bits = 4'd8;
   logic [1:0]    cfg_parity = 2'b00;
   logic          cfg_stop2 = 1'b0;
   logic          loop_en = 1'b0;
   logic          rxd_drv = 1'b1;

   int n_cmp = 0;
   int n_err = 0;
   int frame_cnt = 0;
   int par_cnt = 0;
   int ovr_cnt = 0;

   assign rxd = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_cfg_fifo #(.DATA_WIDTH(DW), .FIFO_AW(AW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tuser     (m_axis_tuser),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .rxd              (rxd),
      .txd              (txd),
      .tx_busy          (tx_busy),
      .rx_busy          (rx_busy),
      .rx_overrun_error (rx_overrun_error),
      .rx_frame_error   (rx_frame_error),
      .rx_parity_error  (rx_parity_error),
      .rx_fifo_count    (rx_fifo_count),
      .prescale         (prescale),
      .cfg_data_bits    (cfg_data_bits),
      .cfg_parity       (cfg_parity),
      .cfg_stop2        (cfg_stop2)
   );

   always @(negedge clk) begin
      if (rx_frame_error) frame_cnt++;
      if (rx_parity_error) par_cnt++;
      if (rx_overrun_error) ovr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for tready at a falling edge, then performs one handshake.
   // Returns at the falling edge of the first frame cycle.
   task automatic tx_send(input logic [DW-1:0] d);
      int t = 0;
      while (!s_axis_tready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("tx_ready_wait", 32'(s_axis_tready), 32'd1);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   // Drives one serial frame at prescale=1 (8 cycles per level). m_axis_tready is
   // raised only during cycle pop_cyc of the frame (-1 = never).
   task automatic rx_send(input logic [7:0] d, input int nbits, input logic has_par,
                          input logic pbit, input logic stopv, input int pop_cyc);
      logic [11:0] lv;
      int          n;
      lv    = '1;
      lv[0] = 1'b0;
      for (int i = 0; i < nbits; i++) lv[1 + i] = d[i];
      n = nbits + 1;
      if (has_par) begin
         lv[n] = pbit;
         n++;
      end
      lv[n] = stopv;
      n++;
      for (int k = 0; k < n * 8; k++) begin
         @(negedge clk);
         rxd_drv       = lv[k / 8];
         m_axis_tready = (k == pop_cyc);
      end
      @(negedge clk);
      rxd_drv       = 1'b1;
      m_axis_tready = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop1;
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [3:0]  bits;
      logic [1:0]  par;
      logic        stop2;
      logic [15:0] presc;
      int          nlev;
      logic [11:0] lev;    // bit i = line level of frame bit i (start first)
      int          plen;   // cycles per level
   } tx_vec_t;

   tx_vec_t tv[5];

   initial begin
      int          f0, p0, o0, t, last;
      logic [7:0]  exp_q[4];

      tv[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 16'd1, 10, 12'h34A, 8};
      tv[1] = '{8'h83, 4'd7,  2'b01, 1'b1, 16'd1, 11, 12'h606, 8};
      tv[2] = '{8'h1F, 4'd5,  2'b10, 1'b0, 16'd1, 8,  12'h0BE, 8};
      tv[3] = '{8'h0A, 4'd2,  2'b11, 1'b0, 16'd0, 7,  12'h054, 8};
      tv[4] = '{8'h3C, 4'd15, 2'b01, 1'b0, 16'd2, 11, 12'h478, 16};

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_rx_busy", 32'(rx_busy), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tuser", 32'(m_axis_tuser), 32'd0);
      check("rst_count", 32'(rx_fifo_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_tready_after", 32'(s_axis_tready), 32'd1);

      // TX frame table
      for (int v = 0; v < 5; v++) begin
         prescale      = tv[v].presc;
         cfg_data_bits = tv[v].bits;
         cfg_parity    = tv[v].par;
         cfg_stop2     = tv[v].stop2;
         tx_send(tv[v].data);
         last = tv[v].nlev * tv[v].plen - 1;
         for (int k = 0; k <= last; k++) begin
            if ((k % tv[v].plen == 0) || (k % tv[v].plen == tv[v].plen - 1))
               check($sformatf("tx%0d_txd_c%0d", v, k), 32'(txd),
                     32'(tv[v].lev[k / tv[v].plen]));
            if (k == 0) begin
               check($sformatf("tx%0d_busy_first", v), 32'(tx_busy), 32'd1);
               check($sformatf("tx%0d_tready_busy", v), 32'(s_axis_tready), 32'd0);
            end
            if (k == last) check($sformatf("tx%0d_busy_last", v), 32'(tx_busy), 32'd1);
            @(negedge clk);
         end
         check($sformatf("tx%0d_busy_end", v), 32'(tx_busy), 32'd0);
         check($sformatf("tx%0d_tready_end", v), 32'(s_axis_tready), 32'd1);
         check($sformatf("tx%0d_txd_end", v), 32'(txd), 32'd1);
      end

      // loopback 8O1 0x3C
      prescale = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
      p0 = par_cnt;
      loop_en = 1'b1;
      tx_send(8'h3C);
      t = 0;
      while (!m_axis_tvalid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("loop_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("loop_tdata", 32'(m_axis_tdata), 32'h3C);
      check("loop_tuser", 32'(m_axis_tuser), 32'd0);
      check("loop_count", 32'(rx_fifo_count), 32'd1);
      t = 0;
      while (tx_busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      loop_en = 1'b0;
      @(negedge clk);
      check("loop_par_pulses", 32'(par_cnt - p0), 32'd0);
      pop1();
      check("loop_count_pop", 32'(rx_fifo_count), 32'd0);

      // forced parity bit 0 on 0x3C, odd parity
      p0 = par_cnt; f0 = frame_cnt;
      rx_send(8'h3C, 8, 1'b1, 1'b0, 1'b1, -1);
      check("perr_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("perr_tdata", 32'(m_axis_tdata), 32'h3C);
      check("perr_tuser", 32'(m_axis_tuser), 32'd1);
      check("perr_pulses", 32'(par_cnt - p0), 32'd1);
      check("perr_no_frame", 32'(frame_cnt - f0), 32'd0);
      pop1();
      check("perr_count_pop", 32'(rx_fifo_count), 32'd0);

      // break: 0x00 with stop bit 0
      cfg_parity = 2'b00;
      f0 = frame_cnt;
      rx_send(8'h00, 8, 1'b0, 1'b0, 1'b0, -1);
      check("brk_frame_pulses", 32'(frame_cnt - f0), 32'd1);
      check("brk_count", 32'(rx_fifo_count), 32'd0);
      check("brk_rx_busy", 32'(rx_busy), 32'd0);

      // FIFO fill, overrun, simultaneous push+pop on full, drain
      o0 = ovr_cnt;
      for (int i = 0; i < 5; i++) rx_send(8'(8'h11 * (i + 1)), 8, 1'b0, 1'b0, 1'b1, -1);
      check("fifo_count_full", 32'(rx_fifo_count), 32'd4);
      check("fifo_overrun", 32'(ovr_cnt - o0), 32'd1);
      check("fifo_head", 32'(m_axis_tdata), 32'h11);
      rx_send(8'h66, 8, 1'b0, 1'b0, 1'b1, 78);
      check("fifo_pushpop_count", 32'(rx_fifo_count), 32'd4);
      check("fifo_pushpop_no_ovr", 32'(ovr_cnt - o0), 32'd1);
      exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d_tvalid", i), 32'(m_axis_tvalid), 32'd1);
         check($sformatf("drain%0d_tdata", i), 32'(m_axis_tdata), 32'(exp_q[i]));
         pop1();
      end
      check("drain_count", 32'(rx_fifo_count), 32'd0);
      pop1();
      check("pop_empty_count", 32'(rx_fifo_count), 32'd0);
      check("pop_empty_tvalid", 32'(m_axis_tvalid), 32'd0);

      // false start: rxd low for 2 cycles
      f0 = frame_cnt; p0 = par_cnt; o0 = ovr_cnt;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         rxd_drv = (k < 2) ? 1'b0 : 1'b1;
         if (k == 4) check("fs_busy_mid", 32'(rx_busy), 32'd1);
         if (k == 10) check("fs_busy_end", 32'(rx_busy), 32'd0);
      end
      check("fs_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("fs_flags", 32'((frame_cnt - f0) + (par_cnt - p0) + (ovr_cnt - o0)), 32'd0);

      // reset in the middle of a TX frame
      tx_send(8'h00);
      repeat (20) @(negedge clk);
      check("mid_txd_low", 32'(txd), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_txd", 32'(txd), 32'd1);
      check("mid_rst_busy", 32'(tx_busy), 32'd0);
      check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_tready", 32'(s_axis_tready), 32'd1);
      check("mid_rel_txd", 32'(txd), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
